// File: rtl/ed25519_pkg.sv
// ed25519_pkg: shared frame geometry, bridge FSM states and the request packer.
//
// Contents:
//   FRAME_TX_W / FRAME_RX_W : request / response frame widths in bits
//   TX_WORDS / RX_WORDS     : 64-bit words per request / response frame
//   SCALAR_W                : width of M, x and y
//   bridge_state_t          : host bridge FSM encoding
//   pack_req()              : builds the request frame {0, M, 0, x, 0, y}
package ed25519_pkg;

  localparam int FRAME_TX_W = 768;
  localparam int FRAME_RX_W = 512;
  localparam int TX_WORDS   = 12;
  localparam int RX_WORDS   = 8;
  localparam int SCALAR_W   = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_RSP
  } bridge_state_t;

  // Each 255-bit operand is padded with a zero MSB so that the frame is
  // three 256-bit slots, sent most-significant word first.
  function automatic logic [FRAME_TX_W-1:0] pack_req(
    input logic [SCALAR_W-1:0] m,
    input logic [SCALAR_W-1:0] x,
    input logic [SCALAR_W-1:0] y
  );
    return {1'b0, m, 1'b0, x, 1'b0, y};
  endfunction

endpackage

// File: rtl/ed25519_host_bridge.sv
// ed25519_host_bridge: host-side end of the ed25519 core word-stream protocol.
//
// Takes one parallel scalar-multiply request, streams it to the core as a
// 12-word frame, gathers the 8-word result frame and presents it as a
// parallel (x, y) response together with the core latency in cycles.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_m/x/y   request port (255-bit operands)
//   o_tx_valid/i_tx_ready, o_tx_data       word stream toward the core
//   i_rx_valid/o_rx_ready, i_rx_data       word stream from the core
//   o_rsp_valid/i_rsp_ready, o_rsp_x/y     response port
//   o_rsp_cycles        last TX handshake to first RX handshake, saturating
//   o_busy              high whenever the FSM is not idle
//   o_state             current FSM state, for debug
//
// Handshakes: on every port a transfer happens on a rising edge where valid
// and ready are both high. A valid source holds valid and data stable until
// that transfer and never withdraws valid without it.
module ed25519_host_bridge
  import ed25519_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int CYC_W  = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [SCALAR_W-1:0] i_req_m,
  input  logic [SCALAR_W-1:0] i_req_x,
  input  logic [SCALAR_W-1:0] i_req_y,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic [WORD_W-1:0]   o_tx_data,
  input  logic                i_rx_valid,
  output logic                o_rx_ready,
  input  logic [WORD_W-1:0]   i_rx_data,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [SCALAR_W-1:0] o_rsp_x,
  output logic [SCALAR_W-1:0] o_rsp_y,
  output logic [CYC_W-1:0]    o_rsp_cycles,
  output logic                o_busy,
  output bridge_state_t       o_state
);

  bridge_state_t state, state_next;

  // The request frame is shifted left one word per TX handshake, so the
  // word on the wire is always the top slice of a flop.
  logic [FRAME_TX_W-1:0] tx_shift;
  // Response words shift in from the bottom. The register is one bit short
  // of a full frame so the discarded b511 simply falls off the top.
  logic [FRAME_RX_W-2:0] rx_buf;
  logic [3:0]            tx_cnt;
  logic [2:0]            rx_cnt;
  logic [CYC_W-1:0]      lat_cnt;

  logic req_hs, tx_hs, rx_hs, rsp_hs, tx_last, rx_last;

  assign req_hs  = i_req_valid & o_req_ready;
  assign tx_hs   = o_tx_valid & i_tx_ready;
  assign rx_hs   = i_rx_valid & o_rx_ready;
  assign rsp_hs  = o_rsp_valid & i_rsp_ready;
  assign tx_last = tx_hs && (tx_cnt == 4'(TX_WORDS - 1));
  assign rx_last = rx_hs && (state == S_RX) && (rx_cnt == 3'(RX_WORDS - 1));

  assign o_tx_data    = tx_shift[FRAME_TX_W-1 -: WORD_W];
  assign o_rsp_x      = rx_buf[FRAME_RX_W-2 -: SCALAR_W];
  assign o_rsp_y      = rx_buf[SCALAR_W-1:0];
  assign o_rsp_cycles = lat_cnt;
  assign o_state      = state;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_hs)  state_next = S_TX;
      S_TX:    if (tx_last) state_next = S_WAIT;
      S_WAIT:  if (rx_hs)   state_next = S_RX;
      S_RX:    if (rx_last) state_next = S_RSP;
      S_RSP:   if (rsp_hs)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_req_ready <= 1'b0;
      o_tx_valid  <= 1'b0;
      o_rx_ready  <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_busy      <= 1'b0;
      tx_shift    <= '0;
      rx_buf      <= '0;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      lat_cnt     <= '0;
    end else begin
      state <= state_next;
      // Port strobes are registered decodes of the next state, so each one
      // is already correct in the first cycle of its state.
      o_req_ready <= (state_next == S_IDLE);
      o_tx_valid  <= (state_next == S_TX);
      o_rx_ready  <= (state_next == S_WAIT) || (state_next == S_RX);
      o_rsp_valid <= (state_next == S_RSP);
      o_busy      <= (state_next != S_IDLE);

      if (req_hs) begin
        tx_shift <= pack_req(i_req_m, i_req_x, i_req_y);
        tx_cnt   <= '0;
      end else if (tx_hs) begin
        tx_shift <= tx_shift << WORD_W;
        tx_cnt   <= tx_cnt + 4'd1;
      end

      // Counting includes the edge of the first RX handshake, so the value
      // equals the number of edges between the two handshakes; it then
      // holds until the next frame has been fully sent.
      if (tx_last) begin
        lat_cnt <= '0;
      end else if ((state == S_WAIT) && (lat_cnt != '1)) begin
        lat_cnt <= lat_cnt + 1'b1;
      end

      if (tx_last) begin
        rx_cnt <= '0;
      end else if (rx_hs) begin
        rx_buf <= {rx_buf[FRAME_RX_W-WORD_W-2:0], i_rx_data};
        rx_cnt <= rx_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ed25519_host_bridge.sv
// tb_ed25519_host_bridge: directed bench for ed25519_host_bridge.
// Two instances share all stimulus; the second uses a 4-bit latency counter
// so saturation is observed alongside the full-width count.
module tb_ed25519_host_bridge;
  import ed25519_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          req_valid = 1'b0;
  logic [254:0]  req_m = '0, req_x = '0, req_y = '0;
  logic          tx_ready = 1'b0;
  logic          rx_valid = 1'b0;
  logic [63:0]   rx_data = '0;
  logic          rsp_ready = 1'b0;

  logic          req_ready, tx_valid, rx_ready, rsp_valid, busy;
  logic [63:0]   tx_data;
  logic [254:0]  rsp_x, rsp_y;
  logic [31:0]   rsp_cycles;
  bridge_state_t state_dbg;

  logic          req_ready_4, tx_valid_4, rx_ready_4, rsp_valid_4, busy_4;
  logic [63:0]   tx_data_4;
  logic [254:0]  rsp_x_4, rsp_y_4;
  logic [3:0]    rsp_cycles_4;
  bridge_state_t state_dbg_4;

  ed25519_host_bridge #(.WORD_W(64), .CYC_W(32)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_m(req_m), .i_req_x(req_x), .i_req_y(req_y),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_data(tx_data),
    .i_rx_valid(rx_valid), .o_rx_ready(rx_ready), .i_rx_data(rx_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_x(rsp_x), .o_rsp_y(rsp_y), .o_rsp_cycles(rsp_cycles),
    .o_busy(busy), .o_state(state_dbg)
  );

  ed25519_host_bridge #(.WORD_W(64), .CYC_W(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready_4),
    .i_req_m(req_m), .i_req_x(req_x), .i_req_y(req_y),
    .o_tx_valid(tx_valid_4), .i_tx_ready(tx_ready), .o_tx_data(tx_data_4),
    .i_rx_valid(rx_valid), .o_rx_ready(rx_ready_4), .i_rx_data(rx_data),
    .o_rsp_valid(rsp_valid_4), .i_rsp_ready(rsp_ready),
    .o_rsp_x(rsp_x_4), .o_rsp_y(rsp_y_4), .o_rsp_cycles(rsp_cycles_4),
    .o_busy(busy_4), .o_state(state_dbg_4)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, want);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0]  basic_word [12];
  logic [63:0]  ones_word  [12];
  logic [63:0]  rx_words   [8];
  logic [254:0] exp_x, exp_y, hold_x, hold_y;
  logic [254:0] all_ones;
  int           hs;

  initial begin
    all_ones = '1;
    for (int k = 0; k < 12; k++) begin
      basic_word[k] = (k == 3) ? 64'd1 : (k == 7) ? 64'd2 : (k == 11) ? 64'd3 : 64'd0;
      // M = all ones, x = 0, y = all ones
      ones_word[k]  = (k == 0 || k == 8) ? 64'h7FFF_FFFF_FFFF_FFFF :
                      (k >= 4 && k <= 7) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
    end
    for (int k = 0; k < 8; k++) rx_words[k] = 64'h0;
    rx_words[0] = 64'h8000_0000_0000_00A0;
    rx_words[4] = 64'h8000_0000_0000_00B0;
    exp_x = 255'(8'hA0) << 192;
    exp_y = 255'(8'hB0) << 192;

    // ---- reset state ----
    step(); step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_cycles", rsp_cycles, 0);
    rst = 1'b0;
    step();
    chk("idle_req_ready", req_ready, 1);

    // ---- basic packing: M=1, x=2, y=3 ----
    req_m = 255'd1; req_x = 255'd2; req_y = 255'd3;
    req_valid = 1'b1; tx_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("req_ready_after_accept", req_ready, 0);
    chk("busy_in_tx", busy, 1);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("basic_valid_%0d", k), tx_valid, 1);
      chk($sformatf("basic_word_%0d", k), tx_data, basic_word[k]);
      step();
    end
    chk("basic_valid_drop", tx_valid, 0);
    chk("wait_rx_ready", rx_ready, 1);

    // ---- latency 40 and RX unpacking ----
    for (int i = 0; i < 39; i++) step();
    chk("wait_no_rsp", rsp_valid, 0);
    for (int k = 0; k < 8; k++) begin
      rx_valid = 1'b1; rx_data = rx_words[k];
      step();
    end
    rx_valid = 1'b0; rx_data = '0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_x", rsp_x, exp_x);
    chk("rsp_y", rsp_y, exp_y);
    chk("cycles_40", rsp_cycles, 40);
    chk("cycles_sat4", rsp_cycles_4, 15);
    chk("rsp_rx_ready_low", rx_ready, 0);

    // ---- response backpressure, with a competing request offered ----
    hold_x = rsp_x; hold_y = rsp_y;
    req_valid = 1'b1; req_m = all_ones; req_x = '0; req_y = all_ones;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_x", rsp_x, exp_x);
      chk("bp_rsp_y", rsp_y, exp_y);
      chk("bp_cycles", rsp_cycles, 40);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_tx_valid", tx_valid, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_rsp_req_ready", req_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_rsp_busy", busy, 0);

    // ---- TX backpressure: ready pattern 1,0,0,1 ----
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    hs = 0;
    for (int c = 0; c < 100 && hs < 12; c++) begin
      tx_ready = (c % 4 == 0) || (c % 4 == 3);
      chk("txbp_valid", tx_valid, 1);
      chk($sformatf("txbp_word_%0d", hs), tx_data, ones_word[hs]);
      step();
      if (tx_ready) hs++;
    end
    tx_ready = 1'b1;
    chk("txbp_handshakes", 256'(hs), 12);
    chk("txbp_valid_drop", tx_valid, 0);

    // ---- immediate RX: latency 1, all-ones payload ----
    for (int k = 0; k < 8; k++) begin
      rx_valid = 1'b1; rx_data = '1;
      step();
    end
    rx_valid = 1'b0; rx_data = '0;
    chk("fast_rsp_valid", rsp_valid, 1);
    chk("fast_rsp_x", rsp_x, all_ones);
    chk("fast_rsp_y", rsp_y, all_ones);
    chk("fast_cycles", rsp_cycles, 1);
    chk("fast_cycles4", rsp_cycles_4, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("fast_done", rsp_valid, 0);

    // ---- reset in the middle of TX ----
    req_m = 255'd1; req_x = 255'd2; req_y = 255'd3;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("midtx_word6", tx_data, basic_word[6]);
    rst = 1'b1;
    step();
    chk("mrst_tx_valid", tx_valid, 0);
    chk("mrst_req_ready", req_ready, 0);
    chk("mrst_rx_ready", rx_ready, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_busy", busy, 0);
    rst = 1'b0;
    step();
    chk("mrst_idle_ready", req_ready, 1);
    chk("mrst_no_tx", tx_valid, 0);
    req_m = all_ones; req_x = '0; req_y = all_ones;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("restart_valid", tx_valid, 1);
    chk("restart_word0", tx_data, ones_word[0]);
    step();
    chk("restart_word1", tx_data, ones_word[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ed25519_host_bridge.md
Name: ed25519_host_bridge

Overview:
Host-side end of the ed25519 core's 64-bit word-stream protocol.
- Accepts one parallel scalar-multiply request (M, x, y; 255 bits each) on a valid/ready port.
- Serializes the request into the 12-word input frame, drives it to the core, and collects the core's 8-word result frame.
- Presents the result as parallel (x, y) on a response valid/ready port, together with a core-latency count.
- Sits between the system/CPU-side register block and the ed25519 core; both share i_clk and i_rst.

Parameters:
- WORD_W, 64: stream word width.
- TX_WORDS, 12: words per request frame (768 bits).
- RX_WORDS, 8: words per response frame (512 bits).
- CYC_W, 32: width of the latency counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when high together with i_req_valid.
- i_req_m  in  255  scalar M.
- i_req_x  in  255  point x.
- i_req_y  in  255  point y.
- o_tx_valid  out  1  word valid toward the core (core's i_in_valid).
- i_tx_ready  in  1  core's o_in_ready.
- o_tx_data  out  64  word toward the core.
- i_rx_valid  in  1  core's o_out_valid.
- o_rx_ready  out  1  drives the core's i_out_ready.
- i_rx_data  in  64  core's o_out_data.
- o_rsp_valid  out  1  result valid.
- i_rsp_ready  in  1  result accepted.
- o_rsp_x  out  255  result x.
- o_rsp_y  out  255  result y.
- o_rsp_cycles  out  CYC_W  cycles from the last TX handshake to the first RX handshake, saturating.
- o_busy  out  1  high in any state other than S_IDLE.

Behaviour:
- Reset: i_rst is synchronous, active-high; clock is i_clk. All outputs registered; every output resets to 0 (o_req_ready also 0); state resets to S_IDLE; counters reset to 0.
- Reset mid-operation: abandons the frame. No partial word may be emitted after reset, and the next request starts at word 0. The core is reset by the same i_rst.
- Request frame layout (768 bits, MSW first): {1'b0, M, 1'b0, x, 1'b0, y}.
  - TX word k is frame[767-64k -: 64].
  - Word 0 holds M[254:192] in bits 62:0, with bit 63 = 0.
- Response frame layout (512 bits, MSW first): {b511, x, b255, y}.
  - RX word k is written to buf[511-64k -: 64].
  - b511 and b255 are don't-care and are discarded.
- FSM, state S_IDLE:
  - o_req_ready = 1.
  - On i_req_valid & o_req_ready: latch the frame, clear tx_cnt, go to S_TX.
- FSM, state S_TX:
  - o_tx_valid = 1 and o_tx_data = word tx_cnt.
  - On i_tx_valid & i_tx_ready: advance tx_cnt.
  - On the handshake with tx_cnt == 11: go to S_WAIT, clear the latency counter, drop o_tx_valid the next cycle.
  - o_tx_data must be stable while o_tx_valid & !i_tx_ready.
- FSM, state S_WAIT:
  - o_rx_ready = 1 and the latency counter increments each cycle, saturating at 2^CYC_W-1.
  - On the first i_rx_valid handshake: store word 0, freeze the counter, go to S_RX.
- FSM, state S_RX:
  - o_rx_ready = 1; each handshake stores word rx_cnt.
  - On the handshake with rx_cnt == 7: go to S_RSP with o_rsp_valid = 1 the next cycle.
- FSM, state S_RSP:
  - o_rsp_valid = 1; o_rsp_x/o_rsp_y/o_rsp_cycles held stable.
  - On i_rsp_ready: go to S_IDLE.
  - Response is valid-before-ready; o_rsp_valid never drops without a handshake.
- Single outstanding frame: the core holds in_ready high even while computing. The bridge therefore never asserts o_tx_valid outside S_TX, and never starts a new frame until the previous response has been handed off.
- i_rx_valid outside S_WAIT/S_RX is ignored (o_rx_ready = 0).
- Throughput: 1 word/cycle when the peer is always ready.
  - Request handshake to first o_tx_valid: 1 cycle.
  - Last RX handshake to o_rsp_valid: 1 cycle.

Decomposition:
- Package ed25519_pkg:
  - Constants FRAME_TX_W = 768, FRAME_RX_W = 512, TX_WORDS, RX_WORDS.
  - Enum bridge_state_t {S_IDLE, S_TX, S_WAIT, S_RX, S_RSP}.
  - Function pack_req(m, x, y) returning the 768-bit frame.
- No sub-module. The TX and RX shift/index logic stays inline, roughly 200 RTL lines.

Test Plan:
- Basic packing: M = 1, x = 2, y = 3 with i_tx_ready = 1 → 12 consecutive words.
  - Words 3, 7, 11 are 1, 2, 3; all other words are 0.
  - o_tx_valid drops after word 11.
- RX unpacking: bench returns 8 words 0x8000_0000_0000_00A0, 0…0, 0x8000_0000_0000_00B0 (word 4), 0…0 → o_rsp_x has the value 0xA0 shifted left by 192 bits, with bit 255 dropped; o_rsp_y likewise uses 0xB0.
- TX backpressure: i_tx_ready toggled 1,0,0,1 → o_tx_data holds each word across stalls; exactly 12 handshakes occur, in order.
- Latency and saturation:
  - CYC_W = 32, first i_rx_valid 40 cycles after the last TX handshake → o_rsp_cycles = 40.
  - CYC_W = 4, same stimulus → o_rsp_cycles = 15.
- Response backpressure: i_rsp_ready low for 5 cycles → o_rsp_valid and data are stable; o_req_ready = 0; o_tx_valid = 0 throughout; after the handshake o_req_ready = 1 the next cycle.
- Reset mid-TX: i_rst asserted after TX word 5 → the next cycle all valid/ready outputs are 0 and o_busy = 0; a new request then emits its word 0 first.
